// File: rtl/regfile_dbg_pkg.sv
// Shared encodings for the register-file debug port: command opcodes,
// FSM states and the default register file geometry.
package regfile_dbg_pkg;

    localparam int XLEN_DEF = 32;
    localparam int NREG_DEF = 32;

    typedef enum logic [1:0] {
        OP_READ    = 2'b00,
        OP_WRITE   = 2'b01,
        OP_DUMP    = 2'b10,
        OP_ILLEGAL = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_WR,
        ST_DRD,
        ST_RESP
    } state_e;

endpackage

// File: rtl/regfile_debug_port.sv
// Debug access to a halted core's register file: single READ/WRITE and a
// full-file DUMP, each answered through a valid/ready response channel.
module regfile_debug_port
    import regfile_dbg_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int NREG = NREG_DEF,
    localparam int AW  = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            core_halted,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [1:0]      cmd_op,
    input  logic [AW-1:0]   cmd_addr,
    input  logic [XLEN-1:0] cmd_wdata,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_data,
    output logic [AW-1:0]   rsp_addr,
    output logic            rsp_last,
    output logic            rsp_err,
    output logic            rf_write,
    output logic [AW-1:0]   rf_rd,
    output logic [XLEN-1:0] rf_rd_val,
    output logic [AW-1:0]   rf_rs1,
    input  logic [XLEN-1:0] rf_rs1_val
);

    localparam logic [AW-1:0] LAST_IDX = AW'(NREG - 1);

    state_e          state_q;
    op_e             op_q;
    logic [AW-1:0]   addr_q;
    logic [XLEN-1:0] wdata_q;
    logic [AW-1:0]   cnt_q;
    logic            rsp_valid_q;
    logic [XLEN-1:0] rsp_data_q;
    logic [AW-1:0]   rsp_addr_q;
    logic            rsp_last_q;
    logic            rsp_err_q;
    logic            rf_write_q;
    logic [AW-1:0]   rf_rd_q;
    logic [XLEN-1:0] rf_rd_val_q;
    logic [AW-1:0]   rf_rs1_q;

    // Ready follows core_halted in the same cycle so a halt during a wait is
    // accepted on the very next edge; reset_n keeps it low while in reset.
    assign cmd_ready = reset_n && core_halted && (state_q == ST_IDLE);

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_addr  = rsp_addr_q;
    assign rsp_last  = rsp_last_q;
    assign rsp_err   = rsp_err_q;
    assign rf_write  = rf_write_q;
    assign rf_rd     = rf_rd_q;
    assign rf_rd_val = rf_rd_val_q;
    assign rf_rs1    = rf_rs1_q;

    // NOTE: all state below is updated with non-blocking assignments so every
    // register samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_READ;
            addr_q      <= '0;
            wdata_q     <= '0;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_addr_q  <= '0;
            rsp_last_q  <= 1'b0;
            rsp_err_q   <= 1'b0;
            rf_write_q  <= 1'b0;
            rf_rd_q     <= '0;
            rf_rd_val_q <= '0;
            rf_rs1_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        op_q     <= op_e'(cmd_op);
                        addr_q   <= cmd_addr;
                        wdata_q  <= cmd_wdata;
                        rf_rs1_q <= cmd_addr;
                        case (op_e'(cmd_op))
                            OP_READ:  state_q <= ST_RD;
                            OP_WRITE: begin
                                state_q     <= ST_WR;
                                rf_write_q  <= (cmd_addr != '0);
                                rf_rd_q     <= cmd_addr;
                                rf_rd_val_q <= cmd_wdata;
                            end
                            OP_DUMP: begin
                                state_q  <= ST_DRD;
                                cnt_q    <= '0;
                                rf_rs1_q <= '0;
                            end
                            default: begin
                                state_q     <= ST_RESP;
                                rsp_valid_q <= 1'b1;
                                rsp_err_q   <= 1'b1;
                                rsp_last_q  <= 1'b1;
                                rsp_data_q  <= '0;
                                rsp_addr_q  <= cmd_addr;
                            end
                        endcase
                    end
                end
                ST_RD: begin
                    rsp_data_q  <= (addr_q == '0) ? '0 : rf_rs1_val;
                    rsp_addr_q  <= addr_q;
                    rsp_last_q  <= 1'b1;
                    rsp_err_q   <= 1'b0;
                    rsp_valid_q <= 1'b1;
                    state_q     <= ST_RESP;
                end
                ST_WR: begin
                    rf_write_q  <= 1'b0;
                    rsp_data_q  <= (addr_q == '0) ? '0 : wdata_q;
                    rsp_addr_q  <= addr_q;
                    rsp_last_q  <= 1'b1;
                    rsp_err_q   <= 1'b0;
                    rsp_valid_q <= 1'b1;
                    state_q     <= ST_RESP;
                end
                ST_DRD: begin
                    rsp_data_q  <= (cnt_q == '0) ? '0 : rf_rs1_val;
                    rsp_addr_q  <= cnt_q;
                    rsp_last_q  <= (cnt_q == LAST_IDX);
                    rsp_err_q   <= 1'b0;
                    rsp_valid_q <= 1'b1;
                    state_q     <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        if (op_q == OP_DUMP && cnt_q != LAST_IDX) begin
                            cnt_q    <= cnt_q + 1'b1;
                            rf_rs1_q <= cnt_q + 1'b1;
                            state_q  <= ST_DRD;
                        end else begin
                            rsp_last_q <= 1'b0;
                            rsp_err_q  <= 1'b0;
                            state_q    <= ST_IDLE;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_debug_port.sv
// Self-checking bench for regfile_debug_port: a behavioural register file,
// an array model of its expected contents and directed plus random commands.
module tb_regfile_debug_port;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int AW   = 5;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            core_halted = 1'b1;
    logic            cmd_valid = 1'b0;
    logic [1:0]      cmd_op = '0;
    logic [AW-1:0]   cmd_addr = '0;
    logic [XLEN-1:0] cmd_wdata = '0;
    logic            rsp_ready = 1'b0;
    logic            cmd_ready, rsp_valid, rsp_last, rsp_err, rf_write;
    logic [XLEN-1:0] rsp_data, rf_rd_val, rf_rs1_val;
    logic [AW-1:0]   rsp_addr, rf_rd, rf_rs1;

    logic [XLEN-1:0] rf    [NREG];
    logic [XLEN-1:0] model [NREG];

    int   n_assert = 0;
    int   n_fail = 0;
    int   wr_pulses = 0;
    int   wr_double = 0;
    logic wr_prev = 1'b0;

    regfile_debug_port #(.XLEN(XLEN), .NREG(NREG)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .core_halted(core_halted),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_addr   (rsp_addr),
        .rsp_last   (rsp_last),
        .rsp_err    (rsp_err),
        .rf_write   (rf_write),
        .rf_rd      (rf_rd),
        .rf_rd_val  (rf_rd_val),
        .rf_rs1     (rf_rs1),
        .rf_rs1_val (rf_rs1_val)
    );

    always #5 clk = ~clk;

    // Register file behind the port: combinational read, write on the edge.
    assign rf_rs1_val = rf[rf_rs1];
    always @(posedge clk) begin
        if (rf_write) begin
            wr_pulses++;
            if (wr_prev) wr_double++;
            rf[rf_rd] <= rf_rd_val;
        end
        wr_prev <= rf_write;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [XLEN-1:0] exp_read(input logic [AW-1:0] a);
        return (a == 0) ? '0 : model[a];
    endfunction

    // Present a command and return #1 after the edge that accepts it.
    task automatic issue(input logic [1:0] op, input logic [AW-1:0] a, input logic [XLEN-1:0] wd);
        int t = 0;
        cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_wdata = wd;
        while (cmd_ready !== 1'b1 && t < 100) begin
            @(posedge clk); #1; t++;
        end
        check("accept_timeout", 128'(t < 100), 128'(1));
        @(posedge clk); #1;
        cmd_valid = 1'b0; cmd_op = 2'($urandom); cmd_addr = AW'($urandom); cmd_wdata = $urandom;
    endtask

    task automatic do_cmd(input logic [1:0] op, input logic [AW-1:0] a, input logic [XLEN-1:0] wd, input string tag);
        logic [XLEN-1:0] exp_d;
        logic            is_err, is_wr;
        int              p0, stall;
        is_err = (op == 2'b11);
        is_wr  = (op == 2'b01);
        exp_d  = (op == 2'b00) ? exp_read(a) : (is_wr && a != 0) ? wd : '0;
        p0 = wr_pulses;
        issue(op, a, wd);
        if (!is_err) begin
            check({tag, "_early_valid"}, 128'(rsp_valid), 128'(0));
            if (is_wr) begin
                check({tag, "_rf_write"}, 128'(rf_write), 128'(a != 0));
                check({tag, "_rf_rd"}, 128'(rf_rd), 128'(a));
                check({tag, "_rf_rd_val"}, 128'(rf_rd_val), 128'(wd));
            end
            @(posedge clk); #1;
            check({tag, "_rf_write_off"}, 128'(rf_write), 128'(0));
            check({tag, "_last"}, 128'(rsp_last), 128'(1));
        end
        check({tag, "_valid"}, 128'(rsp_valid), 128'(1));
        check({tag, "_data"}, 128'(rsp_data), 128'(exp_d));
        check({tag, "_addr"}, 128'(rsp_addr), 128'(a));
        check({tag, "_err"}, 128'(rsp_err), 128'(is_err));
        stall = $urandom_range(0, 2);
        repeat (stall) begin
            @(posedge clk); #1;
            check({tag, "_stall_hold"}, {rsp_valid, rsp_data, rsp_addr}, {1'b1, exp_d, a});
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check({tag, "_done"}, {rsp_valid, rsp_last, rsp_err}, 128'(0));
        check({tag, "_wr_count"}, 128'(wr_pulses - p0), 128'(is_wr && a != 0));
        if (is_wr && a != 0) model[a] = wd;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_ctl"}, {cmd_ready, rsp_valid, rsp_last, rsp_err, rf_write}, 128'(0));
        check({tag, "_data"}, {rsp_data, rf_rd_val}, 128'(0));
        check({tag, "_idx"}, {rsp_addr, rf_rd, rf_rs1}, 128'(0));
    endtask

    initial begin
        int beats, cyc, p0, seen_valid, seen_wr;
        logic            held;
        logic [XLEN-1:0] held_data, old9;

        #2;
        check_outputs_zero("reset");
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b1;
        #1 check("post_reset_idle", 128'(cmd_ready), 128'(1));
        @(posedge clk); #1;

        for (int i = 0; i < NREG; i++) do_cmd(2'b01, AW'(i), $urandom, "init_wr");

        do_cmd(2'b01, 5'd7, 32'h123abc01, "wr7");
        do_cmd(2'b00, 5'd7, '0, "rd7");
        do_cmd(2'b01, 5'd0, 32'h0cdefbc0, "wr0");
        do_cmd(2'b00, 5'd0, '0, "rd0");
        do_cmd(2'b11, 5'd3, $urandom, "illegal");

        for (int i = 0; i < 30; i++)
            do_cmd(2'($urandom_range(0, 1)), AW'($urandom), $urandom, "rand");

        // Command waits while the core is running, then goes on halt.
        core_halted = 1'b0;
        cmd_valid = 1'b1; cmd_op = 2'b00; cmd_addr = 5'd7; cmd_wdata = '0;
        repeat (3) begin
            @(posedge clk); #1;
            check("nohalt_wait", {cmd_ready, rsp_valid}, 128'(0));
        end
        core_halted = 1'b1;
        #1 check("halt_ready", 128'(cmd_ready), 128'(1));
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        check("halt_accept", {cmd_ready, rsp_valid}, 128'(0));
        @(posedge clk); #1;
        check("halt_rsp", {rsp_valid, rsp_data, rsp_addr}, {1'b1, exp_read(5'd7), 5'd7});
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;

        // Full dump with toggling ready and the core resuming mid-dump.
        issue(2'b10, '0, '0);
        beats = 0; cyc = 0; held = 1'b0; held_data = '0;
        while (beats < NREG && cyc < 600) begin
            rsp_ready = cyc[0];
            if (rsp_valid) begin
                if (!held) begin
                    check("dump_addr", 128'(rsp_addr), 128'(beats));
                    check("dump_data", 128'(rsp_data), 128'(exp_read(AW'(beats))));
                    check("dump_last", 128'(rsp_last), 128'(beats == NREG - 1));
                    held_data = rsp_data;
                    held = 1'b1;
                end else begin
                    check("dump_hold", 128'(rsp_data), 128'(held_data));
                end
                if (rsp_ready) begin
                    beats++;
                    held = 1'b0;
                end
            end
            if (beats == 10) core_halted = 1'b0;
            if (beats > 0 && beats < NREG) check("dump_busy_ready", 128'(cmd_ready), 128'(0));
            @(posedge clk); #1;
            cyc++;
        end
        rsp_ready = 1'b0;
        check("dump_beats", 128'(beats), 128'(NREG));
        seen_valid = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (rsp_valid) seen_valid++;
        end
        check("dump_no_extra", 128'(seen_valid), 128'(0));
        core_halted = 1'b1;
        #1 check("dump_idle", 128'(cmd_ready), 128'(1));

        // Reset pulsed while dump beat 5 is presented.
        issue(2'b10, '0, '0);
        rsp_ready = 1'b1;
        cyc = 0;
        while (!(rsp_valid && rsp_addr == 5) && cyc < 100) begin
            @(posedge clk); #1; cyc++;
        end
        check("dump5_reached", 128'(cyc < 100), 128'(1));
        #2 reset_n = 1'b0;
        #1 check_outputs_zero("rst_dump");
        @(posedge clk);
        #3 reset_n = 1'b1;
        rsp_ready = 1'b0;
        #1 check("rst_dump_idle", 128'(cmd_ready), 128'(1));
        seen_valid = 0; seen_wr = wr_pulses;
        repeat (10) begin
            @(posedge clk); #1;
            if (rsp_valid) seen_valid++;
        end
        check("rst_dump_no_beats", 128'(seen_valid), 128'(0));
        check("rst_dump_no_write", 128'(wr_pulses - seen_wr), 128'(0));

        // Reset during the write cycle must suppress the commit.
        old9 = model[9];
        p0 = wr_pulses;
        issue(2'b01, 5'd9, ~old9);
        check("rst_wr_pulse", 128'(rf_write), 128'(1));
        #2 reset_n = 1'b0;
        #1 check("rst_wr_off", 128'(rf_write), 128'(0));
        @(posedge clk);
        #3 reset_n = 1'b1;
        @(posedge clk); #1;
        check("rst_wr_count", 128'(wr_pulses - p0), 128'(0));
        check("rst_wr_no_rsp", 128'(rsp_valid), 128'(0));
        do_cmd(2'b00, 5'd9, '0, "rd9_after_rst");

        check("rf_write_double", 128'(wr_double), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
